instruction_decoder_gate_level: RTL and testbench

//   Registered 4-to-14 instruction decoder. Each 4-bit opcode selects one control line:

---
 rtl/decoder_pkg.sv | 36 +++
 rtl/dec_dff.sv | 29 ++
 rtl/instruction_decoder_gate_level.sv | 81 ++++++++
 tb/tb_instruction_decoder_gate_level.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// ---------------------------------------------------------------------------
// decoder_pkg
//   Shared widths and opcode names for the registered 4-to-14 instruction
//   decoder. Opcodes 0..13 each own one control line. Opcodes from
//   OP_ILLEGAL_MIN upward are unassigned.
// ---------------------------------------------------------------------------
package decoder_pkg;

    localparam int OPCODE_W = 4;
    localparam int CTRL_W   = 14;

    localparam logic [OPCODE_W-1:0] OP_0  = 4'd0;
    localparam logic [OPCODE_W-1:0] OP_1  = 4'd1;
    localparam logic [OPCODE_W-1:0] OP_2  = 4'd2;
    localparam logic [OPCODE_W-1:0] OP_3  = 4'd3;
    localparam logic [OPCODE_W-1:0] OP_4  = 4'd4;
    localparam logic [OPCODE_W-1:0] OP_5  = 4'd5;
    localparam logic [OPCODE_W-1:0] OP_6  = 4'd6;
    localparam logic [OPCODE_W-1:0] OP_7  = 4'd7;
    localparam logic [OPCODE_W-1:0] OP_8  = 4'd8;
    localparam logic [OPCODE_W-1:0] OP_9  = 4'd9;
    localparam logic [OPCODE_W-1:0] OP_10 = 4'd10;
    localparam logic [OPCODE_W-1:0] OP_11 = 4'd11;
    localparam logic [OPCODE_W-1:0] OP_12 = 4'd12;
    localparam logic [OPCODE_W-1:0] OP_13 = 4'd13;

    // First opcode with no control line; equals the number of assigned lines.
    localparam int OP_ILLEGAL_MIN = 14;

    // Opcode recognised by each control line, indexed by line number.
    localparam logic [OPCODE_W-1:0] OP_CODES [CTRL_W] = '{
        OP_0, OP_1, OP_2,  OP_3,  OP_4,  OP_5,  OP_6,
        OP_7, OP_8, OP_9, OP_10, OP_11, OP_12, OP_13
    };

endpackage : decoder_pkg

// File: rtl/dec_dff.sv
// ---------------------------------------------------------------------------
// dec_dff
//   Single-bit D flip-flop with synchronous active-high reset to 0.
//   Ports:
//     clk  in   rising-edge clock
//     rst  in   synchronous reset, active-high, clears q
//     d    in   next-state data
//     q    out  registered data
// ---------------------------------------------------------------------------
module dec_dff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic q_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= 1'b0;
        end else begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule : dec_dff

// File: rtl/instruction_decoder_gate_level.sv
// ---------------------------------------------------------------------------
// instruction_decoder_gate_level
//   Registered 4-to-14 instruction decoder built from NOT/AND gate
//   primitives feeding a bank of dec_dff flops. Opcodes 0..13 assert exactly
//   one bit of F one cycle later; opcodes 14 and 15 assert none.
//   Ports:
//     clk      in   rising-edge clock
//     rst      in   synchronous reset, active-high, clears all outputs
//     OpCode   in   [3:0]  opcode sampled every rising edge
//     F        out  [13:0] one-hot (or all-zero) registered control lines
//     Illegal  out  registered flag for opcodes 14/15 (only when the macro
//                   DECODER_ILLEGAL_FLAG_EN is defined)
// ---------------------------------------------------------------------------
module instruction_decoder_gate_level
    import decoder_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] OpCode,
    output logic [CTRL_W-1:0]   F
`ifdef DECODER_ILLEGAL_FLAG_EN
    ,
    output logic                Illegal
`endif
);

    logic [OPCODE_W-1:0] op_n;
    logic [CTRL_W-1:0]   dn;

    genvar gi;
    genvar gj;

    // Inverted opcode rails.
    generate
        for (gi = 0; gi < OPCODE_W; gi++) begin : g_inv
            not u_not (op_n[gi], OpCode[gi]);
        end
    endgenerate

    // One 4-input AND per assigned opcode. Each input is the true or the
    // inverted rail, chosen at elaboration time from the line's opcode bits,
    // so the selection below is pure wiring, not a mux.
    generate
        for (gi = 0; gi < OP_ILLEGAL_MIN; gi++) begin : g_line
            localparam logic [OPCODE_W-1:0] CODE = OP_CODES[gi];
            logic [OPCODE_W-1:0] lit;

            for (gj = 0; gj < OPCODE_W; gj++) begin : g_lit
                if (CODE[gj]) begin : g_true
                    assign lit[gj] = OpCode[gj];
                end else begin : g_inv_sel
                    assign lit[gj] = op_n[gj];
                end
            end

            and u_and (dn[gi], lit[3], lit[2], lit[1], lit[0]);

            dec_dff u_ff (
                .clk (clk),
                .rst (rst),
                .d   (dn[gi]),
                .q   (F[gi])
            );
        end
    endgenerate

`ifdef DECODER_ILLEGAL_FLAG_EN
    // Opcodes 14 and 15 share the prefix 3'b111, so bit 0 is don't-care.
    logic illegal_d;

    and u_and_illegal (illegal_d, OpCode[3], OpCode[2], OpCode[1]);

    dec_dff u_ff_illegal (
        .clk (clk),
        .rst (rst),
        .d   (illegal_d),
        .q   (Illegal)
    );
`endif

endmodule : instruction_decoder_gate_level

// File: tb/tb_instruction_decoder_gate_level.sv
// ---------------------------------------------------------------------------
// tb_instruction_decoder_gate_level
//   Directed and random checks for instruction_decoder_gate_level: reset,
//   full opcode sweep, latency, mid-stream reset, and a random run checking
//   the one-hot invariant every cycle. Works in both builds of
//   DECODER_ILLEGAL_FLAG_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instruction_decoder_gate_level;
    import decoder_pkg::*;

    logic                clk;
    logic                rst;
    logic [OPCODE_W-1:0] op;
    logic [CTRL_W-1:0]   f;
    logic                illegal;

    int checks   = 0;
    int failures = 0;

    // Hand-computed F for opcodes 0..15.
    logic [CTRL_W-1:0] sweep_exp [16];

    instruction_decoder_gate_level dut (
        .clk     (clk),
        .rst     (rst),
        .OpCode  (op),
        .F       (f)
`ifdef DECODER_ILLEGAL_FLAG_EN
        ,
        .Illegal (illegal)
`endif
    );

`ifndef DECODER_ILLEGAL_FLAG_EN
    assign illegal = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
        end else begin
            $display("ok   %s observed=0x%04h", tag, obs);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_illegal(input string tag, input logic exp);
`ifdef DECODER_ILLEGAL_FLAG_EN
        check(tag, {15'd0, illegal}, {15'd0, exp});
`else
        if (exp && illegal) $display("note %s flag not built", tag);
`endif
    endtask

    initial begin
        logic [CTRL_W-1:0] exp_f;
        logic              exp_ill;
        logic              rst_now;

        sweep_exp[0]  = 14'b00000000000001;
        sweep_exp[1]  = 14'b00000000000010;
        sweep_exp[2]  = 14'b00000000000100;
        sweep_exp[3]  = 14'b00000000001000;
        sweep_exp[4]  = 14'b00000000010000;
        sweep_exp[5]  = 14'b00000000100000;
        sweep_exp[6]  = 14'b00000001000000;
        sweep_exp[7]  = 14'b00000010000000;
        sweep_exp[8]  = 14'b00000100000000;
        sweep_exp[9]  = 14'b00001000000000;
        sweep_exp[10] = 14'b00010000000000;
        sweep_exp[11] = 14'b00100000000000;
        sweep_exp[12] = 14'b01000000000000;
        sweep_exp[13] = 14'b10000000000000;
        sweep_exp[14] = 14'b00000000000000;
        sweep_exp[15] = 14'b00000000000000;

        // Reset held two cycles with a legal opcode present.
        rst = 1'b1;
        op  = 4'b0101;
        tick();
        tick();
        check("reset_f", {2'b0, f}, 16'h0000);
        check_illegal("reset_illegal", 1'b0);
        rst = 1'b0;
        tick();
        check("reset_release_f", {2'b0, f}, 16'h0020);

        // Sweep: one opcode per 20 ns.
        for (int k = 0; k < 16; k++) begin
            op = 4'(k);
            tick();
            check($sformatf("sweep_op%0d_f", k), {2'b0, f}, {2'b0, sweep_exp[k]});
            check_illegal($sformatf("sweep_op%0d_illegal", k), (k >= 14));
            tick();
        end

        // Latency: change just after an edge must not reach F before the next edge.
        op = 4'd3;
        tick();
        check("latency_before_f", {2'b0, f}, 16'h0008);
        op = 4'd9;
        #3;
        check("latency_hold_f", {2'b0, f}, 16'h0008);
        tick();
        check("latency_after_f", {2'b0, f}, 16'h0200);

        // Reset in the middle of operation.
        op = 4'd13;
        tick();
        check("midrst_pre_f", {2'b0, f}, 16'h2000);
        rst = 1'b1;
        tick();
        check("midrst_on_f", {2'b0, f}, 16'h0000);
        rst = 1'b0;
        tick();
        check("midrst_post_f", {2'b0, f}, 16'h2000);

        // Random run with occasional resets.
        for (int c = 0; c < 1000; c++) begin
            op      = 4'($urandom_range(0, 15));
            rst_now = ($urandom_range(0, 31) == 0);
            rst     = rst_now;
            if (rst_now || op >= 4'(OP_ILLEGAL_MIN)) begin
                exp_f = '0;
            end else begin
                exp_f = sweep_exp[op];
            end
            exp_ill = !rst_now && (op >= 4'(OP_ILLEGAL_MIN));
            tick();
            check($sformatf("rand%0d_onehot", c), 16'($countones(f) <= 1), 16'd1);
            check($sformatf("rand%0d_op%0d_rst%0d_f", c, op, rst_now), {2'b0, f}, {2'b0, exp_f});
            check_illegal($sformatf("rand%0d_illegal", c), exp_ill);
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_instruction_decoder_gate_level
